// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: two internal line buffers, nine programmable signed weights,
// saturated signed output. Define CONV3X3_RELU_EN to clamp negative results to zero.
module conv3x3_stream #(
  parameter int unsigned IMG_W  = 34,
  parameter int unsigned IMG_H  = 34,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned COEF_W = 8,
  parameter int unsigned OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     din_valid,
  input  logic [PIX_W-1:0]         din,
  input  logic                     sof,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     dout_valid,
  output logic signed [OUT_W-1:0]  dout,
  output logic                     dout_last
);

  localparam int unsigned ACC_W = PIX_W + COEF_W + 5;
  localparam int unsigned EXT_W = ((OUT_W > ACC_W) ? OUT_W : ACC_W) + 1;
  localparam int unsigned CW    = $clog2(IMG_W);
  localparam int unsigned RW    = $clog2(IMG_H);
  localparam logic signed [EXT_W-1:0] SAT_MAX = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] SAT_MIN = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic signed [COEF_W-1:0] coef_q [9];
  logic signed [COEF_W-1:0] coef_d [9];

  logic [PIX_W-1:0] lb0_q [IMG_W];
  logic [PIX_W-1:0] lb0_d [IMG_W];
  logic [PIX_W-1:0] lb1_q [IMG_W];
  logic [PIX_W-1:0] lb1_d [IMG_W];
  logic [PIX_W-1:0] tap [3];
  logic [PIX_W-1:0] win_q [9];
  logic [PIX_W-1:0] win_d [9];
  logic signed [ACC_W-1:0] prod_q [9];
  logic signed [ACC_W-1:0] prod_d [9];
  logic signed [ACC_W-1:0] rsum_q [3];
  logic signed [ACC_W-1:0] rsum_d [3];

  logic s1_valid_q, s1_valid_d, s1_last_q, s1_last_d;
  logic s2_valid_q, s2_valid_d, s2_last_q, s2_last_d;
  logic s3_valid_q, s3_valid_d, s3_last_q, s3_last_d;
  logic dout_valid_q, dout_valid_d, dout_last_q, dout_last_d;
  logic signed [OUT_W-1:0] dout_q, dout_d;

  logic signed [ACC_W-1:0] sum;
  logic signed [EXT_W-1:0] sum_ext, sat_val;

  // Raster position of the incoming pixel; sof restarts the frame at (0,0).
  always_comb begin
    cur_col = (din_valid && sof) ? '0 : col_q;
    cur_row = (din_valid && sof) ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (din_valid) begin
      if (cur_col == CW'(IMG_W-1)) begin
        col_d = '0;
        row_d = (cur_row == RW'(IMG_H-1)) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_comb begin
    coef_d = coef_q;
    if (coef_we && (coef_addr < 4'd9)) coef_d[coef_addr] = coef_data;
  end

  // S1: line buffers feed the new column into the right edge of the window.
  always_comb begin
    lb0_d  = lb0_q;
    lb1_d  = lb1_q;
    win_d  = win_q;
    tap[0] = lb1_q[cur_col];
    tap[1] = lb0_q[cur_col];
    tap[2] = din;
    s1_valid_d = 1'b0;
    s1_last_d  = 1'b0;
    if (din_valid) begin
      lb1_d[cur_col] = lb0_q[cur_col];
      lb0_d[cur_col] = din;
      for (int i = 0; i < 3; i++) begin
        win_d[3*i]   = win_q[3*i+1];
        win_d[3*i+1] = win_q[3*i+2];
        win_d[3*i+2] = tap[i];
      end
      s1_valid_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
      s1_last_d  = (cur_row == RW'(IMG_H-1)) && (cur_col == CW'(IMG_W-1));
    end
  end

  // S2 multiplies and the adder tree, split into row sums and a final sum.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = ACC_W'($signed({1'b0, win_q[k]})) * ACC_W'(coef_q[k]);
    end
    for (int i = 0; i < 3; i++) begin
      rsum_d[i] = prod_q[3*i] + prod_q[3*i+1] + prod_q[3*i+2];
    end
    s2_valid_d = s1_valid_q;
    s2_last_d  = s1_last_q && s1_valid_q;
    s3_valid_d = s2_valid_q;
    s3_last_d  = s2_last_q && s2_valid_q;
  end

  // Final sum, saturation and optional ReLU into the output register.
  always_comb begin
    sum     = rsum_q[0] + rsum_q[1] + rsum_q[2];
    sum_ext = EXT_W'(sum);
    sat_val = sum_ext;
    if (sum_ext > SAT_MAX) sat_val = SAT_MAX;
    if (sum_ext < SAT_MIN) sat_val = SAT_MIN;
`ifdef CONV3X3_RELU_EN
    if (sat_val[EXT_W-1]) sat_val = '0;
`endif
    dout_valid_d = s3_valid_q;
    dout_last_d  = s3_valid_q && s3_last_q;
    dout_d       = s3_valid_q ? OUT_W'(sat_val) : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q        <= '0;
      row_q        <= '0;
      coef_q       <= '{default: '0};
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      s3_valid_q   <= 1'b0;
      s3_last_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_q       <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      coef_q       <= coef_d;
      s1_valid_q   <= s1_valid_d;
      s1_last_q    <= s1_last_d;
      s2_valid_q   <= s2_valid_d;
      s2_last_q    <= s2_last_d;
      s3_valid_q   <= s3_valid_d;
      s3_last_q    <= s3_last_d;
      dout_valid_q <= dout_valid_d;
      dout_last_q  <= dout_last_d;
      dout_q       <= dout_d;
    end
  end

  // Datapath storage is only ever consumed under a valid flag, so it needs no reset.
  always_ff @(posedge clk) begin
    lb0_q  <= lb0_d;
    lb1_q  <= lb1_d;
    win_q  <= win_d;
    prod_q <= prod_d;
    rsum_q <= rsum_d;
  end

  assign dout_valid = dout_valid_q;
  assign dout_last  = dout_last_q;
  assign dout       = dout_q;

endmodule

// File: tb/tb_conv3x3_stream.sv
// Bench for conv3x3_stream on a 5x5 image with 8-bit output: a frame-level reference
// model pushes each expected result with its due cycle; a monitor pops and compares.
module tb_conv3x3_stream;

  localparam int unsigned W = 5;
  localparam int unsigned H = 5;

  logic              clk;
  logic              rst_n;
  logic              din_valid;
  logic [7:0]        din;
  logic              sof;
  logic              coef_we;
  logic [3:0]        coef_addr;
  logic signed [7:0] coef_data;
  logic              dout_valid;
  logic signed [7:0] dout;
  logic              dout_last;

  conv3x3_stream #(
    .IMG_W(W), .IMG_H(H), .PIX_W(8), .COEF_W(8), .OUT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .sof(sof),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .dout_valid(dout_valid), .dout(dout), .dout_last(dout_last)
  );

  typedef struct {
    logic signed [7:0] val;
    bit                last;
    int                due;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;
  int   results_seen = 0;
  bit   mon_en = 0;
  int   img[H][W];
  int   wm[9];
  int   mr = 0;
  int   mc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard monitor: every cycle either matches the queue head or must be an idle zero.
  always @(negedge clk) begin
    if (mon_en) begin
      if (dout_valid === 1'b1) begin
        results_seen++;
        vectors++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: got dout=%0d last=%0b at cycle %0d, none expected",
                   dout, dout_last, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (dout !== e.val || dout_last !== e.last || cyc != e.due) begin
            errors++;
            $display("FAIL result: got dout=%0d last=%0b cycle=%0d, want dout=%0d last=%0b cycle=%0d",
                     dout, dout_last, cyc, e.val, e.last, e.due);
          end
        end
      end else begin
        vectors++;
        if (dout_valid !== 1'b0 || dout !== 8'sd0 || dout_last !== 1'b0) begin
          errors++;
          $display("FAIL idle_outputs: got valid=%b dout=%0d last=%b, want 0/0/0 at cycle %0d",
                   dout_valid, dout, dout_last, cyc);
        end
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          vectors++;
          errors++;
          $display("FAIL missing_result: want dout=%0d due cycle %0d, got no valid at cycle %0d",
                   sb[0].val, sb[0].due, cyc);
          void'(sb.pop_front());
        end
      end
    end
  end

  // One input cycle; the model applies the weight write before the pixel on the same edge.
  task automatic drive(input bit v, input int pix, input bit s, input bit we, input int a, input int d);
    exp_t e;
    int acc;
    @(negedge clk);
    din_valid = v;
    din       = 8'(pix);
    sof       = s;
    coef_we   = we;
    coef_addr = 4'(a);
    coef_data = 8'(d);
    if (we && a >= 0 && a <= 8) wm[a] = d;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = pix;
      if (mr >= 2 && mc >= 2) begin
        acc = 0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            acc += img[mr-2+i][mc-2+j] * wm[3*i+j];
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
`ifdef CONV3X3_RELU_EN
        if (acc < 0) acc = 0;
`endif
        e.val  = 8'(acc);
        e.last = (mr == H-1) && (mc == W-1);
        e.due  = cyc + 4;
        sb.push_back(e);
      end
      if (mc == W-1) begin
        mc = 0;
        mr = (mr == H-1) ? 0 : mr + 1;
      end else begin
        mc++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic set_weights(input int w0, input int w1, input int w2, input int w3, input int w4,
                             input int w5, input int w6, input int w7, input int w8);
    int w[9];
    w = '{w0, w1, w2, w3, w4, w5, w6, w7, w8};
    for (int k = 0; k < 9; k++) drive(0, 0, 0, 1, k, w[k]);
  endtask

  // mode 0: pixel = 10*r+c, otherwise every pixel equals mode.
  task automatic run_frame(input int mode, input int gap, input bit use_sof, input int npix,
                           input int we_idx, input int we_addr, input int we_val);
    int r, c, p;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / W;
      c = idx % W;
      p = (mode == 0) ? 10*r + c : mode;
      drive(1, p, use_sof && idx == 0, idx == we_idx, we_addr, we_val);
      idle(gap);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() > 0 && n < 40) begin
      idle(1);
      n++;
    end
    idle(4);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: got %0d results still pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic check_count(input string name, input int start, input int want);
    vectors++;
    if (results_seen - start != want) begin
      errors++;
      $display("FAIL %s_count: got %0d results, want %0d", name, results_seen - start, want);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_valid = 0; din = '0; sof = 0; coef_we = 0; coef_addr = '0; coef_data = '0;
    repeat (3) @(negedge clk);
    vectors += 3;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", dout_valid); end
    if (dout !== 8'sd0) begin errors++; $display("FAIL reset_dout: got %0d want 0", dout); end
    if (dout_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", dout_last); end
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) wm[k] = 0;
    mr = 0; mc = 0;
    mon_en = 1;
  endtask

  task automatic test_basic();
    int start = results_seen;
    set_weights(1, 1, 1, 1, 1, 1, 1, 1, 1);
    run_frame(1, 0, 1, 25, -1, 0, 0);
    drain("basic");
    check_count("basic", start, 9);
  endtask

  task automatic test_identity();
    int start = results_seen;
    set_weights(0, 0, 0, 0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 12, 5);
    drive(0, 0, 0, 1, 9, -7);
    run_frame(0, 0, 1, 25, -1, 0, 0);
    set_weights(1, 0, 0, 0, 0, 0, 0, 0, 0);
    run_frame(0, 0, 1, 25, -1, 0, 0);
    drain("identity");
    check_count("identity", start, 18);
  endtask

  task automatic test_saturation();
    int start = results_seen;
    set_weights(127, 127, 127, 127, 127, 127, 127, 127, 127);
    run_frame(255, 0, 1, 25, -1, 0, 0);
    set_weights(-128, -128, -128, -128, -128, -128, -128, -128, -128);
    run_frame(255, 0, 1, 25, -1, 0, 0);
    drain("saturation");
    check_count("saturation", start, 18);
  endtask

  task automatic test_gapped();
    int start = results_seen;
    set_weights(1, 1, 1, 1, 1, 1, 1, 1, 1);
    run_frame(1, 2, 1, 25, -1, 0, 0);
    drain("gapped");
    check_count("gapped", start, 9);
  endtask

  task automatic test_sof_midframe();
    int start = results_seen;
    set_weights(1, 0, 0, 0, 1, 0, 0, 0, 1);
    run_frame(30, 0, 1, 13, -1, 0, 0);
    run_frame(0, 0, 1, 25, -1, 0, 0);
    drain("sof_midframe");
    check_count("sof_midframe", start, 10);
  endtask

  task automatic test_reset_midframe();
    int start;
    set_weights(1, 0, 0, 0, 1, 0, 0, 0, 1);
    run_frame(0, 0, 1, 14, -1, 0, 0);
    @(negedge clk);
    rst_n = 1'b0; din_valid = 0; coef_we = 0; sof = 0;
    sb.delete();
    for (int k = 0; k < 9; k++) wm[k] = 0;
    mr = 0; mc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors += 3;
    if (dout_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", dout_valid); end
    if (dout !== 8'sd0) begin errors++; $display("FAIL midreset_dout: got %0d want 0", dout); end
    if (dout_last !== 1'b0) begin errors++; $display("FAIL midreset_last: got %b want 0", dout_last); end
    start = results_seen;
    run_frame(255, 0, 0, 25, -1, 0, 0);
    drain("zero_weights");
    check_count("zero_weights", start, 9);
    start = results_seen;
    set_weights(1, 1, 1, 1, 1, 1, 1, 1, 1);
    run_frame(1, 0, 1, 25, -1, 0, 0);
    drain("after_reset");
    check_count("after_reset", start, 9);
  endtask

  task automatic test_live_weight();
    int start = results_seen;
    set_weights(0, 0, 0, 0, 1, 0, 0, 0, 0);
    run_frame(0, 0, 1, 25, 14, 4, 2);
    drain("live_weight");
    check_count("live_weight", start, 9);
  endtask

  task automatic test_back_to_back();
    int start = results_seen;
    set_weights(1, 0, 0, 0, 1, 0, 0, 0, 1);
    run_frame(0, 0, 1, 25, -1, 0, 0);
    run_frame(0, 0, 0, 25, -1, 0, 0);
    drain("back_to_back");
    check_count("back_to_back", start, 18);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_identity();
    test_saturation();
    test_gapped();
    test_sof_midframe();
    test_reset_midframe();
    test_live_weight();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
